// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared serdes FSM encoding and default filler byte
//
// Purpose : types and constants used by both the transmit and receive
//           sides of the serial link.
// Contents: serdes_state_e (SYNC/IDLE/DATA), IDLE_BYTE_DEFAULT.
package serdes_pkg;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_DATA = 2'd2
   } serdes_state_e;

   // Comma-like filler byte; 1011_1100 gives the receiver a recognisable pattern.
   localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;

endpackage

// File: rtl/serializer_tx_if.sv
// rtl/serializer_tx_if.sv - parallel byte handshake between producer and serializer
//
// Purpose : groups the upstream valid/ready byte handshake.
// Signals : data_in   - parallel byte (DATA_W bits), producer to serializer
//           valid_in  - data_in is valid this cycle
//           ready_out - serializer holding buffer can accept a byte
// Modports: master (producer side), slave (serializer side).
interface serializer_tx_if #(
   parameter int DATA_W = 8
) ();

   logic [DATA_W-1:0] data_in;
   logic              valid_in;
   logic              ready_out;

   modport master (
      output data_in,
      output valid_in,
      input  ready_out
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output ready_out
   );

endinterface

// File: rtl/tx_retime_flops.sv
// rtl/tx_retime_flops.sv - DEPTH-stage retiming chain for serial bit and data flag
//
// Purpose : delays the 2-bit {flag, bit} pair by exactly DEPTH cycles.
// Ports   : clk_8f - clock, rising edge
//           reset  - synchronous, active-high; clears every stage
//           din_i  - {flag, bit} from the shift register
//           dout_o - {flag, bit} delayed by DEPTH cycles
module tx_retime_flops #(
   parameter int DEPTH = 2
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [1:0] din_i,
   output logic [1:0] dout_o
);

   logic [1:0] stage_q [DEPTH];

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= 2'b00;
         end
      end else begin
         stage_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/serializer_tx.sv
// rtl/serializer_tx.sv - byte-to-serial transmitter with idle filler and sync preamble
//
// Purpose : accepts bytes through a one-entry holding buffer and shifts them
//           out MSB first, one bit per clk_8f cycle. Idle slots carry
//           IDLE_BYTE. After reset MIN_IDLE idle bytes are sent before data.
// Ports   : clk_8f     - the single clock, rising edge
//           reset      - synchronous, active-high
//           up         - slave side of the data_in/valid_in/ready_out handshake
//           data_out0  - serial stream, MSB first, OUT_STAGES cycles of latency
//           active_out - high while data_out0 carries a data-byte bit
module serializer_tx
   import serdes_pkg::*;
#(
   parameter int              DATA_W     = 8,
   parameter logic [DATA_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT,
   parameter int              MIN_IDLE   = 4,
   parameter int              OUT_STAGES = 2
) (
   input  logic             clk_8f,
   input  logic             reset,
   serializer_tx_if.slave   up,
   output logic             data_out0,
   output logic             active_out
);

   localparam int              CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DATA_W - 1);
   localparam logic [7:0]       SYNC_LAST = 8'(MIN_IDLE - 1);

   serdes_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              flag_q, flag_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              ready_q, ready_d;
   logic [7:0]        sync_cnt_q, sync_cnt_d;

   logic              boundary;
   logic              take;
   logic              sync_done;
   logic              may_drain;
   logic [1:0]        retime_out;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      flag_d      = flag_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      sync_cnt_d  = sync_cnt_q;

      boundary  = (cnt_q == LAST_SLOT);
      // ready_q is low whenever the hold is full, so a transfer can never
      // land on the same edge that drains the hold.
      take      = up.valid_in && ready_q;
      sync_done = (state_q == ST_SYNC) && (sync_cnt_q == SYNC_LAST);
      // The boundary that ends the last sync byte already behaves as an IDLE
      // boundary, so the first data byte follows the preamble directly.
      may_drain = (state_q != ST_SYNC) || sync_done;

      if (take) begin
         hold_d      = up.data_in;
         hold_full_d = 1'b1;
      end

      if (boundary) begin
         cnt_d = '0;
         if (may_drain && hold_full_q) begin
            shift_d     = hold_q;
            flag_d      = 1'b1;
            hold_full_d = 1'b0;
            state_d     = ST_DATA;
         end else begin
            shift_d = IDLE_BYTE;
            flag_d  = 1'b0;
            if (state_q == ST_SYNC && !sync_done) begin
               sync_cnt_d = sync_cnt_q + 8'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end else begin
         cnt_d   = cnt_q + CNT_W'(1);
         shift_d = {shift_q[DATA_W-2:0], 1'b0};
      end

      ready_d = !hold_full_d;
   end

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state_q     <= ST_SYNC;
         cnt_q       <= '0;
         shift_q     <= IDLE_BYTE;
         flag_q      <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         ready_q     <= 1'b0;
         sync_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         flag_q      <= flag_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         ready_q     <= ready_d;
         sync_cnt_q  <= sync_cnt_d;
      end
   end

   assign up.ready_out = ready_q;

   tx_retime_flops #(
      .DEPTH (OUT_STAGES)
   ) u_retime (
      .clk_8f (clk_8f),
      .reset  (reset),
      .din_i  ({flag_q, shift_q[DATA_W-1]}),
      .dout_o (retime_out)
   );

   assign data_out0  = retime_out[0];
   assign active_out = retime_out[1];

endmodule

// File: tb/tb_serializer_tx.sv
// tb/tb_serializer_tx.sv - self-checking bench for serializer_tx
module tb_serializer_tx;

   localparam logic [7:0] IDLE = 8'hBC;
   localparam int         MIN_IDLE = 4;
   localparam int         STAGES = 2;

   logic clk_8f = 1'b0;
   logic reset  = 1'b1;
   logic data_out0;
   logic active_out;

   serializer_tx_if #(.DATA_W(8)) up_if ();

   serializer_tx dut (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .up         (up_if),
      .data_out0  (data_out0),
      .active_out (active_out)
   );

   always #5 clk_8f = ~clk_8f;

   int checks = 0;
   int errors = 0;

   // Slot-level reference model.
   logic       ready_m;
   logic       hold_full_m;
   logic [7:0] hold_m;
   logic [7:0] cur_byte;
   logic       cur_act;
   logic [1:0] dq[$];
   int         u;

   logic obs_bit [0:1023];
   logic obs_act [0:1023];
   logic obs_rdy [0:1023];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, u);
      end
   endtask

   task automatic model_reset();
      ready_m     = 1'b0;
      hold_full_m = 1'b0;
      hold_m      = 8'h00;
      cur_byte    = IDLE;
      cur_act     = 1'b0;
      dq.delete();
      for (int i = 0; i < STAGES; i++) dq.push_back(2'b00);
      u = 0;
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic r);
      logic [1:0] e;
      int slot;
      @(negedge clk_8f);
      e = dq.pop_front();
      chk("data_out0", {31'd0, data_out0}, {31'd0, e[0]});
      chk("active_out", {31'd0, active_out}, {31'd0, e[1]});
      chk("ready_out", {31'd0, up_if.ready_out}, {31'd0, ready_m});
      if (u < 1024) begin
         obs_bit[u] = data_out0;
         obs_act[u] = active_out;
         obs_rdy[u] = up_if.ready_out;
      end
      dq.push_back({cur_act, cur_byte[7 - (u % 8)]});
      up_if.valid_in = v;
      up_if.data_in  = d;
      reset          = r;
      if (r) begin
         model_reset();
      end else begin
         if (u % 8 == 7) begin
            slot = (u + 1) / 8;
            if (slot >= MIN_IDLE && hold_full_m) begin
               cur_byte    = hold_m;
               cur_act     = 1'b1;
               hold_full_m = 1'b0;
            end else begin
               cur_byte = IDLE;
               cur_act  = 1'b0;
            end
         end
         if (v && ready_m) begin
            hold_m      = d;
            hold_full_m = 1'b1;
         end
         ready_m = !hold_full_m;
         u++;
      end
   endtask

   function automatic logic [7:0] get_byte(input int start);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = obs_bit[start+i];
      return b;
   endfunction

   function automatic int count_act(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (obs_act[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int first_act(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) if (obs_act[i] === 1'b1) return i;
      return -1;
   endfunction

   initial begin
      logic [7:0] sendq[$];
      logic       sent;
      int         f;

      up_if.valid_in = 1'b0;
      up_if.data_in  = 8'h00;

      // Scenario 1: idle stream, then A5 at cycle 1 with an ignored byte while full.
      reset = 1'b1;
      repeat (3) @(posedge clk_8f);
      model_reset();
      for (int i = 0; i < 60; i++) begin
         step((i >= 1 && i <= 30), (i == 1) ? 8'hA5 : 8'h5A, 1'b0);
      end
      chk("rst_bit0", {31'd0, obs_bit[0]}, 32'd0);
      chk("rst_act0", {31'd0, obs_act[0]}, 32'd0);
      chk("rst_rdy0", {31'd0, obs_rdy[0]}, 32'd0);
      chk("rdy_c1", {31'd0, obs_rdy[1]}, 32'd1);
      chk("rdy_c2", {31'd0, obs_rdy[2]}, 32'd0);
      chk("idle_c2", {24'd0, get_byte(2)}, {24'd0, IDLE});
      chk("idle_c26", {24'd0, get_byte(26)}, {24'd0, IDLE});
      chk("a5_bits", {24'd0, get_byte(34)}, 32'hA5);
      chk("a5_act_in", count_act(34, 41), 8);
      chk("a5_act_tot", count_act(0, 59), 8);
      chk("idle_c42", {24'd0, get_byte(42)}, {24'd0, IDLE});

      // Scenario 2: back-to-back 01, FF, 80.
      step(1'b0, 8'h00, 1'b1);
      sendq = '{8'h01, 8'hFF, 8'h80};
      for (int i = 0; i < 80; i++) begin
         if (ready_m && sendq.size() > 0) begin
            step(1'b1, sendq[0], 1'b0);
            void'(sendq.pop_front());
         end else begin
            step(1'b0, 8'h00, 1'b0);
         end
      end
      f = first_act(0, 79);
      chk("b2b_first", f, 34);
      if (f >= 0) begin
         chk("b2b_run", count_act(f, f + 23), 24);
         chk("b2b_byte0", {24'd0, get_byte(f)}, 32'h01);
         chk("b2b_byte1", {24'd0, get_byte(f + 8)}, 32'hFF);
         chk("b2b_byte2", {24'd0, get_byte(f + 16)}, 32'h80);
      end
      chk("b2b_total", count_act(0, 79), 24);

      // Scenario 3: reset pulsed in the middle of a data byte.
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 39; i++) begin
         step((i == 1), 8'h3C, (i == 38));
      end
      sent = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (ready_m && !sent) begin
            step(1'b1, 8'h66, 1'b0);
            sent = 1'b1;
         end else begin
            step(1'b0, 8'h00, 1'b0);
         end
      end
      chk("mid_rst_bit", {31'd0, obs_bit[0]}, 32'd0);
      chk("mid_rst_act", {31'd0, obs_act[0]}, 32'd0);
      chk("mid_rst_rdy1", {31'd0, obs_rdy[1]}, 32'd1);
      chk("mid_rst_first", first_act(0, 59), 34);
      chk("mid_rst_byte", {24'd0, get_byte(34)}, 32'h66);
      chk("mid_rst_total", count_act(0, 59), 8);

      // Scenario 4: random traffic with occasional resets against the model.
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 299) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serializer_tx.md
SERIALIZER_TX -- requirements
Module: serializer_tx

Interface
REQ-001 Parameter DATA_W, default 8: parallel byte width; serial slot length in clk_8f cycles.
REQ-002 Parameter IDLE_BYTE, default 8'hBC: filler byte sent when no data is pending.
REQ-003 Parameter MIN_IDLE, default 4: idle bytes sent after reset before any data byte.
REQ-004 Parameter OUT_STAGES, default 2: retiming flops between the shift register and data_out0 (range 1..8).
REQ-005 Port clk_8f, input, 1: the single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port data_in, input, DATA_W: parallel byte from the upstream producer.
REQ-008 Port valid_in, input, 1: data_in is valid this cycle.
REQ-009 Port ready_out, output, 1: registered; the holding buffer can accept a byte.
REQ-010 Port data_out0, output, 1: serial stream, MSB first.
REQ-011 Port active_out, output, 1: high while data_out0 carries a data-byte bit; low for idle-byte bits.

Function
REQ-012 A transfer SHALL occur on any edge with valid_in=1 and ready_out=1; data_in is written to a one-entry holding buffer.
REQ-013 ready_out SHALL equal NOT(hold_full), registered; valid_in with ready_out=0 SHALL be ignored.
REQ-014 A 3-bit slot counter SHALL count 0..DATA_W-1 and wrap; on non-boundary cycles the shift register shifts left by one.
REQ-015 At the boundary (counter=DATA_W-1), the shift register SHALL load the next byte and the counter SHALL wrap to 0.
REQ-016 The next byte SHALL be the hold contents if the state is IDLE or DATA and the hold is full (hold empties); otherwise it SHALL be IDLE_BYTE.
REQ-017 FSM states:
- SYNC: after reset; counts complete idle bytes; enters IDLE at the boundary ending byte MIN_IDLE; the hold is never drained in SYNC.
- IDLE: enters DATA at a boundary with the hold full.
- DATA: stays in DATA at a boundary with the hold full; returns to IDLE at a boundary with the hold empty.
REQ-018 The internal serial bit SHALL be shift_reg[DATA_W-1]. A per-slot data flag SHALL travel with it.
REQ-019 data_out0 and active_out SHALL be the internal bit and flag delayed by exactly OUT_STAGES cycles.
REQ-020 The hold draining at a boundary and a new transfer SHALL NOT coincide. The hold refills at the earliest one cycle later, giving a sustained throughput of one byte per DATA_W cycles with no idle gap.
REQ-021 Arrival of a byte mid-slot SHALL NOT disturb the current slot; the byte waits for the next boundary.

Reset
REQ-022 While reset=1 at an edge, the block SHALL:
- load shift_reg with IDLE_BYTE and set counter=0 and state=SYNC;
- clear the hold, the sync byte count and all OUT_STAGES flops;
- drive data_out0=0, active_out=0 and ready_out=0.
REQ-023 ready_out SHALL rise on the first edge with reset=0.
REQ-024 Reset asserted mid-slot or mid-byte SHALL discard the hold and the partial byte without completing it. The pipeline flops are cleared, so data_out0 and active_out read 0 at the next edge.
REQ-025 The first internal bit after reset is IDLE_BYTE MSB, on the first edge with reset=0.

Structure
REQ-026 A shared package serdes_pkg SHALL hold the FSM state encoding (SYNC, IDLE, DATA) and the default IDLE_BYTE constant, shared with the receive-side blocks.
REQ-027 The OUT_STAGES retiming chain SHALL be a sub-module tx_retime_flops: parameterised depth, 2-bit wide (bit and flag), same clock and reset.

Verification (defaults; cycle 0 = first edge with reset=0)
REQ-028 Reset released, valid_in=0 -> data_out0 repeats 1,0,1,1,1,1,0,0 from cycle 2; active_out stays 0; ready_out=1 from cycle 1.
REQ-029 Byte 8'hA5 offered at cycle 1:
- ready_out goes 0 at cycle 2;
- data_out0 reads 1,0,1,0,0,1,0,1 on cycles 34..41, with active_out=1 on exactly those cycles;
- IDLE_BYTE resumes from cycle 42.
REQ-030 Back-to-back bytes 8'h01, 8'hFF, 8'h80, each presented as soon as ready_out=1 -> 24 contiguous active_out cycles; data_out0 matches each byte MSB first; no idle byte between them.
REQ-031 valid_in=1 with ready_out=0 (hold full, different data_in value) -> the ignored byte never appears on data_out0.
REQ-032 reset pulsed for one cycle at bit 4 of a data byte -> data_out0 and active_out read 0 on the following edge; ready_out returns 1 one cycle after reset deasserts; 4 full idle bytes precede any new data; the truncated byte is never resent.
